// File: rtl/amba_pkg.sv
`default_nettype none
// ============================================================================
// Package  : amba_pkg
// Brief    : AHB-Lite encodings, command record and master FSM state type
//            shared by the AHB-Lite initiator and its testbench.
// Revision : 1.0 - initial release
// ============================================================================
package amba_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HRESP_OKAY    = 2'b00;
    localparam logic [1:0]  HRESP_ERROR   = 2'b01;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [31:0] CUSTOM_BASE   = 32'hA016_0000;

    // One queued command: {we, adr, wdata}
    localparam int CMD_W = 65;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/amba_master_iface_if.sv
`default_nettype none
// ============================================================================
// Module   : amba_master_iface_if
// Brief    : Command/response and AHB-Lite signal bundle for the initiator.
//            'master' is the initiator's view, 'slave' the opposite side
//            (requester plus bus slave).
// Revision : 1.0 - initial release
// ============================================================================
interface amba_master_iface_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_wdata, rsp_ready,
               hrdata, hready, hresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               haddr, htrans, hwrite, hsize, hwdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_wdata, rsp_ready,
               hrdata, hready, hresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               haddr, htrans, hwrite, hsize, hwdata
    );

endinterface
`default_nettype wire

// File: rtl/amba_master_iface_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Synchronous command FIFO. Pointers carry one extra wrap bit so
//            full and empty are distinguished without a separate counter.
//            Push is refused while full, even if a pop happens that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int             c_AW  = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_ONE = (c_AW + 1)'(1);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pointer update; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/amba_master_iface.sv
`default_nettype none
// ============================================================================
// Module   : amba_master_iface
// Brief    : Single-master AHB-Lite initiator. Queued word read/write
//            commands become non-pipelined NONSEQ transfers, one at a time,
//            each answered by exactly one response (data, bus error,
//            timeout or misaligned-address error).
// Revision : 1.0 - initial release
// ============================================================================
module amba_master_iface #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    amba_master_iface_if.master bus
);
    import amba_pkg::*;

    // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th stall aborts
    localparam int              c_CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    state_t             r_state,       w_state_nxt;
    logic [c_CW-1:0]    r_wait_cnt,    w_wait_cnt_nxt;
    logic [31:0]        r_haddr,       w_haddr_nxt;
    logic [1:0]         r_htrans,      w_htrans_nxt;
    logic               r_hwrite,      w_hwrite_nxt;
    logic [31:0]        r_hwdata,      w_hwdata_nxt;
    logic [31:0]        r_wdata,       w_wdata_nxt;
    logic               r_rsp_valid,   w_rsp_valid_nxt;
    logic [31:0]        r_rsp_rdata,   w_rsp_rdata_nxt;
    logic               r_rsp_err,     w_rsp_err_nxt;
    logic               r_rsp_timeout, w_rsp_timeout_nxt;

    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CMD_W-1:0]   w_head_raw;
    cmd_t               w_head;
    logic               w_wait_expired;

    cmd_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.cmd_valid),
        .push_data ({bus.cmd_we, bus.cmd_adr, bus.cmd_wdata}),
        .pop       (w_pop),
        .pop_data  (w_head_raw),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_head         = cmd_t'(w_head_raw);
    assign w_wait_expired = (r_wait_cnt == c_CNT_LAST);

    assign bus.cmd_ready   = !w_full;
    assign bus.haddr       = r_haddr;
    assign bus.htrans      = r_htrans;
    assign bus.hwrite      = r_hwrite;
    assign bus.hsize       = HSIZE_WORD;
    assign bus.hwdata      = r_hwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

    // Next-state and next-output decode for the transfer sequencer
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_haddr_nxt       = r_haddr;
        w_htrans_nxt      = r_htrans;
        w_hwrite_nxt      = r_hwrite;
        w_hwdata_nxt      = r_hwdata;
        w_wdata_nxt       = r_wdata;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_pop             = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.adr[1:0] != 2'b00) begin
                        // Rejected locally; the bus never sees it
                        w_rsp_err_nxt     = 1'b1;
                        w_rsp_timeout_nxt = 1'b0;
                        w_rsp_rdata_nxt   = '0;
                        w_state_nxt       = ST_RESP;
                    end else begin
                        w_haddr_nxt    = w_head.adr;
                        w_hwrite_nxt   = w_head.we;
                        w_wdata_nxt    = w_head.we ? w_head.wdata : 32'h0;
                        w_htrans_nxt   = HTRANS_NONSEQ;
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                if (bus.hready) begin
                    w_htrans_nxt   = HTRANS_IDLE;
                    w_hwdata_nxt   = r_wdata;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = ST_DATA;
                end else if (w_wait_expired) begin
                    w_htrans_nxt      = HTRANS_IDLE;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_wait_cnt_nxt    = '0;
                    w_state_nxt       = ST_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bus.hready) begin
                    w_rsp_err_nxt     = (bus.hresp == HRESP_ERROR);
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = (!r_hwrite && bus.hresp != HRESP_ERROR)
                                        ? bus.hrdata : 32'h0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_wait_cnt_nxt    = '0;
                    w_state_nxt       = ST_RESP;
                end else if (w_wait_expired) begin
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_wait_cnt_nxt    = '0;
                    w_state_nxt       = ST_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + c_CNT_ONE;
                end
            end

            ST_RESP: begin
                // A misaligned command arrives here with valid still low,
                // so it presents one cycle after entry
                if (!r_rsp_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                end else if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and all bus/response output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_haddr       <= '0;
            r_htrans      <= HTRANS_IDLE;
            r_hwrite      <= 1'b0;
            r_hwdata      <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_haddr       <= w_haddr_nxt;
            r_htrans      <= w_htrans_nxt;
            r_hwrite      <= w_hwrite_nxt;
            r_hwdata      <= w_hwdata_nxt;
            r_wdata       <= w_wdata_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

endmodule
`default_nettype wire
